// File: rtl/syscall_unit.sv
// syscall_unit: syscall execution, CPU run/pause/halt control, PC enable and board counters
module syscall_unit #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SCNT_W     = 16,
    parameter logic [31:0] HALT_CODE  = 32'd10,
    parameter logic [31:0] PAUSE_CODE = 32'd50,
    parameter logic [31:0] DEC_CODE   = 32'd1,
    parameter logic [31:0] HEX_CODE   = 32'd34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IsSyscall,
    input  logic [31:0]       V0,
    input  logic [31:0]       A0,
    input  logic              Go,
    output logic              PCEn,
    output logic              Halted,
    output logic              Paused,
    output logic [31:0]       DispData,
    output logic              DispHex,
    output logic              DispStb,
    output logic [CNT_W-1:0]  InstrCnt,
    output logic [SCNT_W-1:0] SyscallCnt
);
    typedef enum logic [1:0] {RUN, PAUSE, HALT} state_t;

    state_t              state_q, state_d;
    logic                go_q, go_d;
    logic [31:0]         disp_data_q, disp_data_d;
    logic                disp_hex_q, disp_hex_d;
    logic                disp_stb_q, disp_stb_d;
    logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;
    logic [SCNT_W-1:0]   syscall_cnt_q, syscall_cnt_d;
    logic                commit, sc, go_edge, disp_dec, disp_hx;

    // a syscall only takes effect when its instruction commits
    always_comb begin
        commit   = (state_q == RUN);
        sc       = commit & IsSyscall;
        go_edge  = Go & ~go_q;
        disp_dec = sc & (V0 == DEC_CODE);
        disp_hx  = sc & (V0 == HEX_CODE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // next-state: halt is sticky until reset, pause needs a fresh go edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = (sc && V0 == HALT_CODE)  ? HALT :
                               (sc && V0 == PAUSE_CODE) ? PAUSE : RUN;
            PAUSE:   state_d = go_edge ? RUN : PAUSE;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // outputs decoded from the registered state
    always_comb begin
        PCEn   = (state_q == RUN);
        Halted = (state_q == HALT);
        Paused = (state_q == PAUSE);
    end

    // display, go history and counter next values
    always_comb begin
        go_d          = Go;
        disp_data_d   = (disp_dec | disp_hx) ? A0 : disp_data_q;
        disp_hex_d    = disp_hx ? 1'b1 : disp_dec ? 1'b0 : disp_hex_q;
        disp_stb_d    = disp_dec | disp_hx;
        instr_cnt_d   = (commit && !(&instr_cnt_q)) ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
        syscall_cnt_d = sc ? syscall_cnt_q + SCNT_W'(1) : syscall_cnt_q;
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            go_q          <= 1'b0;
            disp_data_q   <= '0;
            disp_hex_q    <= 1'b0;
            disp_stb_q    <= 1'b0;
            instr_cnt_q   <= '0;
            syscall_cnt_q <= '0;
        end else begin
            go_q          <= go_d;
            disp_data_q   <= disp_data_d;
            disp_hex_q    <= disp_hex_d;
            disp_stb_q    <= disp_stb_d;
            instr_cnt_q   <= instr_cnt_d;
            syscall_cnt_q <= syscall_cnt_d;
        end
    end

    assign DispData   = disp_data_q;
    assign DispHex    = disp_hex_q;
    assign DispStb    = disp_stb_q;
    assign InstrCnt   = instr_cnt_q;
    assign SyscallCnt = syscall_cnt_q;
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: scoreboard bench for syscall_unit, plus a narrow-counter instance for saturation/wrap
module tb_syscall_unit;
    logic        clk = 1'b0;
    logic        rst, IsSyscall, Go;
    logic [31:0] V0, A0;
    logic        PCEn, Halted, Paused, DispHex, DispStb;
    logic [31:0] DispData, InstrCnt;
    logic [15:0] SyscallCnt;
    logic        s_PCEn, s_Halted, s_Paused, s_DispHex, s_DispStb;
    logic [31:0] s_DispData;
    logic [2:0]  s_InstrCnt, s_SyscallCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    syscall_unit u_dut (
        .clk(clk), .rst(rst), .IsSyscall(IsSyscall), .V0(V0), .A0(A0), .Go(Go),
        .PCEn(PCEn), .Halted(Halted), .Paused(Paused), .DispData(DispData),
        .DispHex(DispHex), .DispStb(DispStb), .InstrCnt(InstrCnt), .SyscallCnt(SyscallCnt)
    );

    syscall_unit #(.CNT_W(3), .SCNT_W(3)) u_small (
        .clk(clk), .rst(rst), .IsSyscall(IsSyscall), .V0(V0), .A0(A0), .Go(Go),
        .PCEn(s_PCEn), .Halted(s_Halted), .Paused(s_Paused), .DispData(s_DispData),
        .DispHex(s_DispHex), .DispStb(s_DispStb), .InstrCnt(s_InstrCnt), .SyscallCnt(s_SyscallCnt)
    );

    typedef struct packed {
        logic        pcen, halted, paused, hex, stb;
        logic [31:0] data, icnt;
        logic [15:0] scnt;
        logic [2:0]  icnt_s, scnt_s;
    } exp_t;

    exp_t exp_q[$];

    // reference model: 0=run 1=pause 2=halt
    int          m_state;
    logic        m_go_q, m_hex, m_stb;
    logic [31:0] m_data, m_icnt;
    logic [15:0] m_scnt;
    logic [2:0]  m_icnt_s, m_scnt_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic sys, input logic [31:0] v0, input logic [31:0] a0,
                        input logic go, input logic r);
        logic commit, scv;
        exp_t e;
        rst = r; IsSyscall = sys; V0 = v0; A0 = a0; Go = go;
        commit = (m_state == 0);
        scv    = commit && sys;
        if (r) begin
            m_state = 0; m_hex = 0; m_stb = 0; m_data = 0;
            m_icnt = 0; m_scnt = 0; m_icnt_s = 0; m_scnt_s = 0;
        end else begin
            m_stb = 0;
            if (scv && (v0 == 1 || v0 == 34)) begin
                m_data = a0; m_hex = (v0 == 34); m_stb = 1;
            end
            if (commit) begin
                if (m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 1;
                if (m_icnt_s != 3'd7) m_icnt_s = m_icnt_s + 1;
            end
            if (scv) begin
                m_scnt = m_scnt + 1;
                m_scnt_s = m_scnt_s + 1;
            end
            if (scv && v0 == 10) m_state = 2;
            else if (scv && v0 == 50) m_state = 1;
            else if (m_state == 1 && go && !m_go_q) m_state = 0;
        end
        m_go_q = r ? 1'b0 : go;
        e = '{pcen: m_state == 0, halted: m_state == 2, paused: m_state == 1, hex: m_hex,
              stb: m_stb, data: m_data, icnt: m_icnt, scnt: m_scnt, icnt_s: m_icnt_s,
              scnt_s: m_scnt_s};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("pcen", PCEn, e.pcen);
        check("halted", Halted, e.halted);
        check("paused", Paused, e.paused);
        check("disp_data", DispData, e.data);
        check("disp_hex", DispHex, e.hex);
        check("disp_stb", DispStb, e.stb);
        check("instr_cnt", InstrCnt, e.icnt);
        check("syscall_cnt", SyscallCnt, e.scnt);
        check("small_instr_cnt", s_InstrCnt, e.icnt_s);
        check("small_syscall_cnt", s_SyscallCnt, e.scnt_s);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; IsSyscall = 0; V0 = 0; A0 = 0; Go = 0;
        m_state = 0; m_go_q = 0; m_hex = 0; m_stb = 0; m_data = 0;
        m_icnt = 0; m_scnt = 0; m_icnt_s = 0; m_scnt_s = 0;
        @(negedge clk);
        // reset, then plain instructions
        repeat (2) step(0, 0, 0, 0, 1);
        check("t1_reset_pcen", PCEn, 1);
        repeat (5) step(0, 0, 0, 0, 0);
        check("t1_icnt", InstrCnt, 5);
        check("t1_scnt", SyscallCnt, 0);
        check("t1_data", DispData, 0);
        // hex display, strobe lasts one cycle
        step(1, 34, 32'hDEAD_BEEF, 0, 0);
        check("t2_data", DispData, 32'hDEAD_BEEF);
        check("t2_stb", DispStb, 1);
        step(0, 34, 32'h1234_5678, 0, 0);
        check("t2_stb_drop", DispStb, 0);
        // decimal display and a partial-match halt code that must be ignored
        step(1, 1, 32'd12345, 0, 0);
        check("dec_hex", DispHex, 0);
        step(1, 32'h0001_000A, 32'h55, 0, 0);
        check("partial_halt", PCEn, 1);
        // pause with Go already high: needs a fresh edge
        step(1, 50, 0, 1, 0);
        check("t3_paused", Paused, 1);
        repeat (4) step(1, 10, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("t3_resumed", PCEn, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        // halt is sticky against go and syscalls
        step(1, 10, 0, 0, 0);
        check("t4_halted", Halted, 1);
        for (int i = 0; i < 100; i++) step(1, (i % 2) ? 32'd50 : 32'd34, i, 1'($urandom_range(0, 1)), 0);
        check("t4_still_halted", PCEn, 0);
        step(0, 0, 0, 0, 1);
        check("t4_reset_icnt", InstrCnt, 0);
        // unknown code only bumps the syscall counter
        step(1, 7, 32'hFFFF, 0, 0);
        check("t5_unknown_stb", DispStb, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 65535; i++) step(1, 7, 0, 0, 0);
        check("t5_scnt_max", SyscallCnt, 16'hFFFF);
        step(1, 7, 0, 0, 0);
        check("t5_scnt_wrap", SyscallCnt, 0);
        check("small_icnt_sat", s_InstrCnt, 7);
        // reset wins over a halting syscall
        step(1, 10, 0, 0, 1);
        check("t6_run", PCEn, 1);
        check("t6_icnt", InstrCnt, 0);
        check("t6_scnt", SyscallCnt, 0);
        step(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
